// File: rtl/jtag_debug_sys_probe_ctrl_if.sv
// Avalon-MM register bus between the JTAG master and the probe controller.
// Read latency is fixed at one cycle and there is no waitrequest.
interface jtag_debug_sys_probe_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [2:0]        address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, write, writedata, input  readdata);
  modport slave  (input  address, write, writedata, output readdata);
endinterface

// File: rtl/jtag_debug_sys_probe_ctrl.sv
// Breakpoint / single-step sequencer on the CPU retire stream.
// It snapshots PC and instruction on a hit, requests a halt and exposes its state over Avalon-MM.
//
// state     | meaning
// ST_IDLE   | disarmed, retires ignored
// ST_ARMED  | watching retires for a breakpoint or step hit, counting retires
// ST_HALTED | hit captured, halt_req held until a resume write
module jtag_debug_sys_probe_ctrl #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [DATA_W-1:0] BP_RESET = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  jtag_debug_sys_probe_ctrl_if.slave    bus,
  input  logic [DATA_W-1:0]             pc_in_i,
  input  logic [DATA_W-1:0]             instr_in_i,
  input  logic                          pc_valid_i,
  output logic                          halt_req_o,
  output logic                          irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              bp_en_q, bp_en_d;
  logic              step_q, step_d;
  logic              irq_en_q, irq_en_d;
  logic              bp_hit_q, bp_hit_d;
  logic              step_hit_q, step_hit_d;
  logic              cnt_sat_q, cnt_sat_d;
  logic              halt_req_q, halt_req_d;
  logic              irq_q, irq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bp_addr_q, bp_addr_d;
  logic [DATA_W-1:0] snap_pc_q, snap_pc_d;
  logic [DATA_W-1:0] snap_instr_q, snap_instr_d;
  logic [DATA_W-1:0] live_pc_q;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic ctrl_wr;
  logic bp_wr;
  logic hit_bp;
  logic hit;
  logic enter_armed;

  assign ctrl_wr = bus.write && (bus.address == 3'd0);
  assign bp_wr   = bus.write && (bus.address == 3'd2);
  // Hit terms use the register values in force before this edge's writes land.
  assign hit_bp  = pc_valid_i && bp_en_q && (pc_in_i == bp_addr_q);
  assign hit     = hit_bp || (pc_valid_i && step_q);

  always_comb begin
    state_d      = state_q;
    bp_en_d      = bp_en_q;
    step_d       = step_q;
    irq_en_d     = irq_en_q;
    bp_hit_d     = bp_hit_q;
    step_hit_d   = step_hit_q;
    cnt_sat_d    = cnt_sat_q;
    cnt_d        = cnt_q;
    halt_req_d   = halt_req_q;
    snap_pc_d    = snap_pc_q;
    snap_instr_d = snap_instr_q;
    bp_addr_d    = bp_wr ? bus.writedata : bp_addr_q;
    enter_armed  = 1'b0;

    if (ctrl_wr) begin
      bp_en_d  = bus.writedata[1];
      step_d   = bus.writedata[2];
      irq_en_d = bus.writedata[3];
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && bus.writedata[0]) begin
          state_d     = ST_ARMED;
          enter_armed = 1'b1;
        end
      end
      ST_ARMED: begin
        // A disarm write takes priority over a coincident retire: no count, no capture.
        if (ctrl_wr && !bus.writedata[0]) begin
          state_d = ST_IDLE;
        end else if (pc_valid_i) begin
          if (!(&cnt_q)) begin
            cnt_d     = cnt_q + 1'b1;
            cnt_sat_d = &cnt_d;
          end
          if (hit) begin
            snap_pc_d    = pc_in_i;
            snap_instr_d = instr_in_i;
            bp_hit_d     = hit_bp;
            step_hit_d   = step_q;
            halt_req_d   = 1'b1;
            state_d      = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (ctrl_wr && bus.writedata[4]) begin
          halt_req_d = 1'b0;
          if (bus.writedata[0]) begin
            state_d     = ST_ARMED;
            enter_armed = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        halt_req_d = 1'b0;
      end
    endcase

    if (enter_armed) begin
      cnt_d      = '0;
      cnt_sat_d  = 1'b0;
      bp_hit_d   = 1'b0;
      step_hit_d = 1'b0;
    end

    irq_d = (state_d == ST_HALTED) && irq_en_d;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      3'd0:    readdata_d = DATA_W'({irq_en_q, step_q, bp_en_q, state_q != ST_IDLE});
      3'd1:    readdata_d = DATA_W'({cnt_sat_q, step_hit_q, bp_hit_q, state_q});
      3'd2:    readdata_d = bp_addr_q;
      3'd3:    readdata_d = snap_pc_q;
      3'd4:    readdata_d = snap_instr_q;
      3'd5:    readdata_d = DATA_W'(cnt_q);
      3'd6:    readdata_d = live_pc_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bp_en_q      <= 1'b0;
      step_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_hit_q   <= 1'b0;
      cnt_sat_q    <= 1'b0;
      cnt_q        <= '0;
      halt_req_q   <= 1'b0;
      irq_q        <= 1'b0;
      bp_addr_q    <= BP_RESET;
      snap_pc_q    <= '0;
      snap_instr_q <= '0;
      live_pc_q    <= '0;
      readdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      bp_en_q      <= bp_en_d;
      step_q       <= step_d;
      irq_en_q     <= irq_en_d;
      bp_hit_q     <= bp_hit_d;
      step_hit_q   <= step_hit_d;
      cnt_sat_q    <= cnt_sat_d;
      cnt_q        <= cnt_d;
      halt_req_q   <= halt_req_d;
      irq_q        <= irq_d;
      bp_addr_q    <= bp_addr_d;
      snap_pc_q    <= snap_pc_d;
      snap_instr_q <= snap_instr_d;
      live_pc_q    <= pc_in_i;
      readdata_q   <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign halt_req_o   = halt_req_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_jtag_debug_sys_probe_ctrl.sv
// Directed plan plus randomized retire/register traffic checked against a behavioural model.
module tb_jtag_debug_sys_probe_ctrl;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] BP_RESET = 32'h0000_0040;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        pc_valid = 1'b0;
  logic        halt_req;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  jtag_debug_sys_probe_ctrl_if #(.DATA_W(DATA_W)) bus ();

  jtag_debug_sys_probe_ctrl #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .BP_RESET (BP_RESET)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pc_in_i    (pc_in),
    .instr_in_i (instr_in),
    .pc_valid_i (pc_valid),
    .halt_req_o (halt_req),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 armed, 2 halted
  int          m_state;
  bit          m_bp_en, m_step, m_irq_en, m_bph, m_sth;
  int          m_cnt;
  logic [31:0] m_bp, m_spc, m_sins, m_live;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_bp_en = 0; m_step = 0; m_irq_en = 0; m_bph = 0; m_sth = 0;
    m_cnt = 0; m_bp = BP_RESET; m_spc = '0; m_sins = '0; m_live = '0;
  endtask

  task automatic m_enter_armed();
    m_state = 1; m_cnt = 0; m_bph = 0; m_sth = 0;
  endtask

  function automatic logic [31:0] m_rd(input int a);
    case (a)
      0: return {28'd0, m_irq_en, m_step, m_bp_en, m_state != 0};
      1: return 32'(m_state) | (32'(m_bph) << 2) | (32'(m_sth) << 3) | (32'(m_cnt == CNT_MAX) << 4);
      2: return m_bp;
      3: return m_spc;
      4: return m_sins;
      5: return 32'(m_cnt);
      6: return m_live;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge(input int a, input logic w, input logic [31:0] wd,
                        input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bit cw     = w && (a == 0);
    bit hb     = v && m_bp_en && (pc == m_bp);
    bit hs     = v && m_step;
    case (m_state)
      0: begin
        if (cw) begin m_bp_en = wd[1]; m_step = wd[2]; m_irq_en = wd[3]; end
        if (cw && wd[0]) m_enter_armed();
      end
      1: begin
        if (cw && !wd[0]) begin
          m_bp_en = wd[1]; m_step = wd[2]; m_irq_en = wd[3];
          m_state = 0;
        end else begin
          if (v && m_cnt < CNT_MAX) m_cnt++;
          if (hb || hs) begin
            m_spc = pc; m_sins = ins; m_bph = hb; m_sth = hs; m_state = 2;
          end
          if (cw) begin m_bp_en = wd[1]; m_step = wd[2]; m_irq_en = wd[3]; end
        end
      end
      default: begin
        if (cw) begin m_bp_en = wd[1]; m_step = wd[2]; m_irq_en = wd[3]; end
        if (cw && wd[4]) begin
          if (wd[0]) m_enter_armed();
          else m_state = 0;
        end
      end
    endcase
    if (w && a == 2) m_bp = wd;
    m_live = pc;
  endtask

  // One bus/retire cycle; inputs driven #1 after an edge, outputs checked #1 after the next.
  task automatic cyc(input int a, input logic w, input logic [31:0] wd,
                     input logic v, input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] exp_rd;
    bus.address   = 3'(a);
    bus.write     = w;
    bus.writedata = wd;
    pc_valid      = v;
    pc_in         = pc;
    instr_in      = ins;
    @(posedge clk);
    #1;
    exp_rd = m_rd(a);
    m_edge(a, w, wd, v, pc, ins);
    chk("readdata", bus.readdata, exp_rd);
    chk("halt_req", 32'(halt_req), 32'(m_state == 2));
    chk("irq", 32'(irq), 32'(m_state == 2 && m_irq_en));
    bus.write = 1'b0;
    pc_valid  = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cyc(a, 1'b1, d, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    cyc(a, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    d = bus.readdata;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins);
    cyc(0, 1'b0, 32'd0, 1'b1, pc, ins);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    m_reset();
    chk("rst_halt", 32'(halt_req), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd", bus.readdata, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  logic [31:0] d;

  initial begin
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0;
    m_reset();
    #3;
    chk("init_halt", 32'(halt_req), 32'd0);
    chk("init_rd", bus.readdata, 32'd0);
    #9 reset_n = 1'b1;

    for (int a = 0; a < 8; a++) begin
      rd(a, d);
      chk("reset_map", d, (a == 2) ? BP_RESET : 32'd0);
    end

    wr(2, 32'h0000_0100);
    wr(0, 32'h3);
    retire(32'h0000_00FC, 32'h1111_1111);
    chk("no_halt_fc", 32'(halt_req), 32'd0);
    retire(32'h0000_0100, 32'h00A0_0093);
    chk("bp_halt", 32'(halt_req), 32'd1);
    rd(3, d); chk("snap_pc", d, 32'h100);
    rd(4, d); chk("snap_instr", d, 32'h00A0_0093);
    rd(1, d); chk("status_bp", d, 32'h6);
    rd(5, d); chk("cnt_two", d, 32'd2);
    retire(32'h0000_0100, 32'h0);
    rd(5, d); chk("cnt_halted", d, 32'd2);

    wr(0, 32'h10);
    chk("resume_halt", 32'(halt_req), 32'd0);
    rd(1, d); chk("status_idle", d & 32'h3, 32'd0);
    retire(32'h0000_0104, 32'h0);
    retire(32'h0000_0100, 32'h0);
    rd(5, d); chk("cnt_idle", d, 32'd2);

    wr(0, 32'hD);
    retire(32'h0000_0200, 32'h1234_5678);
    chk("step_irq", 32'(irq), 32'd1);
    rd(3, d); chk("snap_step", d, 32'h200);
    rd(1, d); chk("status_step", d, 32'hA);
    wr(0, 32'h15);
    chk("rearm_irq", 32'(irq), 32'd0);
    rd(1, d); chk("status_rearm", d, 32'h1);
    rd(5, d); chk("cnt_rearm", d, 32'd0);
    rd(3, d); chk("snap_keep", d, 32'h200);

    wr(0, 32'h3);
    cyc(0, 1'b1, 32'h0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("disarm_wins", 32'(halt_req), 32'd0);
    rd(1, d); chk("disarm_state", d & 32'h3, 32'd0);
    rd(3, d); chk("disarm_snap", d, 32'h200);

    wr(0, 32'h1);
    for (int i = 0; i < 20; i++) retire(32'h0000_1000 + 32'(i * 4), 32'(i));
    rd(5, d); chk("cnt_sat_val", d, 32'(CNT_MAX));
    rd(1, d); chk("status_sat", d, 32'h11);

    wr(0, 32'h3);
    retire(32'h0000_0100, 32'h5);
    pulse_reset();
    for (int a = 0; a < 8; a++) begin
      rd(a, d);
      chk("post_reset_map", d, (a == 2) ? BP_RESET : 32'd0);
    end

    for (int i = 0; i < 4000; i++) begin
      int          a;
      logic        w, v;
      logic [31:0] wd, pc;
      a  = int'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      if (a == 2) wd = 32'h100 + 32'($urandom_range(0, 3) * 4);
      if (a == 0 && $urandom_range(0, 1) == 1) wd[2] = 1'b0;
      v  = 1'($urandom_range(0, 1));
      pc = 32'h100 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 799) == 0) pulse_reset();
      else cyc(a, w, wd, v, pc, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
